hdmi_timing_ctrl: RTL
=====================

Name: hdmi_timing_ctrl

Overview:
- Programmable video-timing controller that sequences the pixel datapath feeding the TMDS encoders and serializer.
- Runs on the pixel clock and generates hsync, vsync, the draw-area enable and pixel coordinates.
- Issues a one-cycle-early pixel request to the framebuffer / pattern source.
- Accepts a new timing configuration at any time and applies it glitch-free at the next frame boundary; supports clean start/stop.

Parameters:
- CW, 12, width of all counters and config fields.
- DEF_H_ACTIVE, 640, reset horizontal active pixels.
- DEF_H_TOTAL, 800, reset horizontal total pixels per line.
- DEF_H_SYNC_START, 656, reset hsync start column.
- DEF_H_SYNC_END, 752, reset hsync end column (exclusive).
- DEF_V_ACTIVE, 480, reset vertical active lines.
- DEF_V_TOTAL, 525, reset lines per frame.
- DEF_V_SYNC_START, 490, reset vsync start line.
- DEF_V_SYNC_END, 492, reset vsync end line (exclusive).
- SYNC_POL, 1, 1 = syncs active-high, 0 = active-low.

Ports:
- clk  in  1  pixel clock (25 MHz for 640x480).
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  level; 1 = run timing, 0 = stop at end of current frame.
- cfg_valid  in  1  one-cycle strobe; samples all cfg_* inputs.
- cfg_h_active, cfg_h_total, cfg_h_sync_start, cfg_h_sync_end  in  CW each  new horizontal timing.
- cfg_v_active, cfg_v_total, cfg_v_sync_start, cfg_v_sync_end  in  CW each  new vertical timing.
- cfg_pending  out  1  accepted config waiting for the frame boundary.
- cfg_err  out  1  one-cycle pulse when a config is rejected.
- pix_req  out  1  high one cycle before draw_area; the source must present pixel data on the next cycle.
- draw_area  out  1  active video (drives encoder VDE).
- hsync, vsync  out  1 each  syncs, polarity set by SYNC_POL (drive the blue-channel CD input).
- pos_x, pos_y  out  CW each  current column/line, valid in all states.
- frame_start  out  1  one-cycle pulse at (0,0) of each frame.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async assert, sync deassert via normal flop behaviour):
  - state = IDLE; counters = 0; shadow and active config = DEF_*.
  - All pulse and enable outputs = 0; hsync and vsync = inactive level.
- States:
  - IDLE --enable=1--> RUN.
  - RUN --enable=0--> DRAIN.
  - DRAIN --enable=1--> RUN (no gap).
  - DRAIN --last pixel of frame (pos_x = h_total-1 and pos_y = v_total-1)--> IDLE.
  - In IDLE: counters held at 0, outputs inactive.
- Counters (RUN and DRAIN):
  - pos_x increments each cycle and wraps at h_total-1.
  - pos_y increments on the x wrap and wraps at v_total-1.
  - All outputs are registered and aligned to pos_x/pos_y (zero skew among them).
- Decodes:
  - draw_area = (pos_x < h_active) and (pos_y < v_active).
  - hsync active for h_sync_start <= pos_x < h_sync_end; vsync likewise on pos_y.
  - pix_req = draw_area evaluated at the next (x, y), including across the line and frame wrap.
  - frame_start asserted with the first (0,0) after IDLE->RUN and with every (0,0) thereafter.
- Config validation (on cfg_valid):
  - Accept only if active < sync_start < sync_end <= total, total >= 2, and active >= 1, for both axes.
  - Reject: cfg_err pulses the next cycle; shadow and cfg_pending are unchanged.
  - Accept: shadow <= cfg; cfg_pending = 1. A later accepted cfg overwrites the shadow (last wins).
- Apply:
  - Active config <= shadow on the cycle the counters wrap to (0,0), or on the IDLE->RUN transition; cfg_pending clears on that cycle.
  - If cfg_valid coincides with the wrap cycle, the new config applies at this wrap.
  - The active config never changes mid-frame.
- Reset mid-frame: immediate return to the reset state; a pending config is discarded.
- Bus widths: all comparisons are unsigned CW-bit. No arithmetic overflow is possible given validation.

Decomposition:
- Shared package hdmi_pkg:
  - Timing record type (h/v active, total, sync_start, sync_end).
  - DEF_* 640x480 constants.
  - State enum {IDLE, RUN, DRAIN}.
  - Validation function for the timing record.
- Natural sub-module: hdmi_axis_counter.
  - One axis counter with its decodes (active, sync, next-active), instantiated twice (H counts every cycle, V counts on H wrap).

Test Plan:
- Reset then enable=1 → frame_start at cycle 1 after enable. hsync high for x = 656..751 (96 cycles). vsync high for lines 490..491. draw_area for 640 cycles per line on lines 0..479. 800x525 cycles between frame_start pulses.
- pix_req check → pix_req leads draw_area by exactly one cycle, including at (799,524)→(0,0) and (799,y)→(0,y+1).
- cfg_valid mid-frame with 800/600 timing (h_active 800, h_total 1056, hsync 840..968; v_active 600, v_total 628, vsync 601..605) → current frame finishes with 640x480 timing. cfg_pending stays 1 until the wrap; the next frame uses 1056x628.
- cfg with h_sync_end = 600 < h_sync_start = 656 → cfg_err pulse, cfg_pending stays 0, timing unchanged; then two back-to-back valid cfgs → the second one applies.
- enable=0 at line 100 → busy stays 1 and the frame completes to (799,524), then IDLE with outputs inactive. Re-enable during DRAIN → no gap, no extra frame_start.
- rst_n low at (300,200) with a config pending → all outputs inactive immediately. After release and enable, DEF timing is in use and cfg_pending = 0.

Source files
------------

// File: rtl/hdmi_pkg.sv
// Shared types, reset timing and config validation for the HDMI timing controller.
package hdmi_pkg;

  localparam int HDMI_CW = 12;

  // 640x480 @ 60 Hz reset timing
  localparam int DEF_H_ACTIVE     = 640;
  localparam int DEF_H_TOTAL      = 800;
  localparam int DEF_H_SYNC_START = 656;
  localparam int DEF_H_SYNC_END   = 752;
  localparam int DEF_V_ACTIVE     = 480;
  localparam int DEF_V_TOTAL      = 525;
  localparam int DEF_V_SYNC_START = 490;
  localparam int DEF_V_SYNC_END   = 492;

  typedef struct packed {
    logic [HDMI_CW-1:0] h_active;
    logic [HDMI_CW-1:0] h_total;
    logic [HDMI_CW-1:0] h_sync_start;
    logic [HDMI_CW-1:0] h_sync_end;
    logic [HDMI_CW-1:0] v_active;
    logic [HDMI_CW-1:0] v_total;
    logic [HDMI_CW-1:0] v_sync_start;
    logic [HDMI_CW-1:0] v_sync_end;
  } timing_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // One axis is usable when active < sync_start < sync_end <= total,
  // with at least one active and two total positions.
  function automatic logic axis_ok(input logic [HDMI_CW-1:0] act,
                                   input logic [HDMI_CW-1:0] tot,
                                   input logic [HDMI_CW-1:0] ss,
                                   input logic [HDMI_CW-1:0] se);
    return (act != '0) && (tot >= HDMI_CW'(2)) &&
           (act < ss) && (ss < se) && (se <= tot);
  endfunction

  function automatic logic timing_ok(input timing_t t);
    return axis_ok(t.h_active, t.h_total, t.h_sync_start, t.h_sync_end) &&
           axis_ok(t.v_active, t.v_total, t.v_sync_start, t.v_sync_end);
  endfunction

endpackage

// File: rtl/hdmi_axis_counter.sv
// One timing axis: position counter plus decodes of the position it moves to
// (active, sync) and of the position after that (next-active, for pix_req).
module hdmi_axis_counter #(
  parameter int CW = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,        // next cycle is idle: return to 0
  input  logic          inc,        // advance this cycle
  input  logic          nxt_inc,    // axis advances again on the following cycle
  input  logic [CW-1:0] cur_total,  // total of the config in force now (wrap test)
  input  logic [CW-1:0] active,     // config in force after this edge
  input  logic [CW-1:0] total,
  input  logic [CW-1:0] sync_start,
  input  logic [CW-1:0] sync_end,
  output logic [CW-1:0] pos_q,
  output logic          last,       // current position is the final one
  output logic          new_last,   // position after this edge is the final one
  output logic          in_act,
  output logic          in_sync,
  output logic          nxt_act
);

  logic [CW-1:0] pos_d;
  logic [CW-1:0] pos_nn;

  // Next position, and the one after it, with wrap at total-1
  always_comb begin
    last     = (pos_q == cur_total - 1'b1);
    pos_d    = pos_q;
    if (clr) begin
      pos_d = '0;
    end else if (inc) begin
      pos_d = last ? '0 : pos_q + 1'b1;
    end
    new_last = (pos_d == total - 1'b1);
    pos_nn   = pos_d;
    if (nxt_inc) begin
      pos_nn = new_last ? '0 : pos_d + 1'b1;
    end
    in_act  = (pos_d < active);
    in_sync = (pos_d >= sync_start) && (pos_d < sync_end);
    nxt_act = (pos_nn < active);
  end

  // Position register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q <= '0;
    end else begin
      pos_q <= pos_d;
    end
  end

endmodule

// File: rtl/hdmi_timing_ctrl.sv
// Programmable video timing controller: syncs, draw enable, coordinates and
// an early pixel request, with config changes taking effect only at (0,0).
module hdmi_timing_ctrl
  import hdmi_pkg::*;
#(
  parameter int CW               = HDMI_CW,
  parameter int DEF_H_ACTIVE     = hdmi_pkg::DEF_H_ACTIVE,
  parameter int DEF_H_TOTAL      = hdmi_pkg::DEF_H_TOTAL,
  parameter int DEF_H_SYNC_START = hdmi_pkg::DEF_H_SYNC_START,
  parameter int DEF_H_SYNC_END   = hdmi_pkg::DEF_H_SYNC_END,
  parameter int DEF_V_ACTIVE     = hdmi_pkg::DEF_V_ACTIVE,
  parameter int DEF_V_TOTAL      = hdmi_pkg::DEF_V_TOTAL,
  parameter int DEF_V_SYNC_START = hdmi_pkg::DEF_V_SYNC_START,
  parameter int DEF_V_SYNC_END   = hdmi_pkg::DEF_V_SYNC_END,
  parameter int SYNC_POL         = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic          cfg_valid,
  input  logic [CW-1:0] cfg_h_active,
  input  logic [CW-1:0] cfg_h_total,
  input  logic [CW-1:0] cfg_h_sync_start,
  input  logic [CW-1:0] cfg_h_sync_end,
  input  logic [CW-1:0] cfg_v_active,
  input  logic [CW-1:0] cfg_v_total,
  input  logic [CW-1:0] cfg_v_sync_start,
  input  logic [CW-1:0] cfg_v_sync_end,
  output logic          cfg_pending,
  output logic          cfg_err,
  output logic          pix_req,
  output logic          draw_area,
  output logic          hsync,
  output logic          vsync,
  output logic [CW-1:0] pos_x,
  output logic [CW-1:0] pos_y,
  output logic          frame_start,
  output logic          busy
);

  localparam timing_t RST_CFG = '{
    h_active:     HDMI_CW'(DEF_H_ACTIVE),
    h_total:      HDMI_CW'(DEF_H_TOTAL),
    h_sync_start: HDMI_CW'(DEF_H_SYNC_START),
    h_sync_end:   HDMI_CW'(DEF_H_SYNC_END),
    v_active:     HDMI_CW'(DEF_V_ACTIVE),
    v_total:      HDMI_CW'(DEF_V_TOTAL),
    v_sync_start: HDMI_CW'(DEF_V_SYNC_START),
    v_sync_end:   HDMI_CW'(DEF_V_SYNC_END)
  };
  localparam logic SYNC_ACT = (SYNC_POL != 0);

  state_t  state_q, state_d;
  timing_t cfg_q, cfg_d, shadow_q, shadow_d, cfg_in, shadow_eff;
  logic    pending_q, pending_d, err_q, err_d;
  logic    draw_q, draw_d, pix_q, pix_d, hsync_q, hsync_d, vsync_q, vsync_d;
  logic    fs_q, fs_d, busy_q, busy_d;
  logic    running, wrap, go_idle, apply, cfg_ok, cfg_take;

  logic [CW-1:0] h_pos, v_pos;
  logic h_last, h_new_last, h_act, h_sync, h_nxt_act;
  logic v_last, v_new_last, v_act, v_sync, v_nxt_act;

  assign cfg_in = '{
    h_active: cfg_h_active, h_total: cfg_h_total,
    h_sync_start: cfg_h_sync_start, h_sync_end: cfg_h_sync_end,
    v_active: cfg_v_active, v_total: cfg_v_total,
    v_sync_start: cfg_v_sync_start, v_sync_end: cfg_v_sync_end
  };

  assign running = (state_q != ST_IDLE);
  assign wrap    = running && h_last && v_last;

  // Run/stop sequencing: a stop request finishes the current frame first
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (enable) state_d = ST_RUN;
      ST_RUN:   if (!enable) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (enable)    state_d = ST_RUN;
        else if (wrap) state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // Config shadowing; a strobe on the wrap cycle is taken into this wrap
  always_comb begin
    go_idle    = (state_d == ST_IDLE);
    cfg_ok     = timing_ok(cfg_in);
    cfg_take   = cfg_valid && cfg_ok;
    shadow_eff = cfg_take ? cfg_in : shadow_q;
    apply      = !go_idle && (!running || wrap);
    shadow_d   = shadow_eff;
    cfg_d      = apply ? shadow_eff : cfg_q;
    pending_d  = apply ? 1'b0 : (cfg_take ? 1'b1 : pending_q);
    err_d      = cfg_valid && !cfg_ok;
  end

  hdmi_axis_counter #(.CW(CW)) u_h (
    .clk(clk), .rst_n(rst_n), .clr(go_idle), .inc(running), .nxt_inc(1'b1),
    .cur_total(cfg_q.h_total), .active(cfg_d.h_active), .total(cfg_d.h_total),
    .sync_start(cfg_d.h_sync_start), .sync_end(cfg_d.h_sync_end),
    .pos_q(h_pos), .last(h_last), .new_last(h_new_last),
    .in_act(h_act), .in_sync(h_sync), .nxt_act(h_nxt_act)
  );

  hdmi_axis_counter #(.CW(CW)) u_v (
    .clk(clk), .rst_n(rst_n), .clr(go_idle), .inc(running && h_last),
    .nxt_inc(h_new_last),
    .cur_total(cfg_q.v_total), .active(cfg_d.v_active), .total(cfg_d.v_total),
    .sync_start(cfg_d.v_sync_start), .sync_end(cfg_d.v_sync_end),
    .pos_q(v_pos), .last(v_last), .new_last(v_new_last),
    .in_act(v_act), .in_sync(v_sync), .nxt_act(v_nxt_act)
  );

  // Output decodes for the position being entered, so they align with pos_x/pos_y
  always_comb begin
    busy_d  = !go_idle;
    draw_d  = !go_idle && h_act && v_act;
    pix_d   = !go_idle && h_nxt_act && v_nxt_act;
    hsync_d = (!go_idle && h_sync) ? SYNC_ACT : !SYNC_ACT;
    vsync_d = (!go_idle && v_sync) ? SYNC_ACT : !SYNC_ACT;
    fs_d    = !go_idle && (!running || wrap);
  end

  // Control, config and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cfg_q     <= RST_CFG;
      shadow_q  <= RST_CFG;
      pending_q <= 1'b0;
      err_q     <= 1'b0;
      draw_q    <= 1'b0;
      pix_q     <= 1'b0;
      hsync_q   <= !SYNC_ACT;
      vsync_q   <= !SYNC_ACT;
      fs_q      <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cfg_q     <= cfg_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      err_q     <= err_d;
      draw_q    <= draw_d;
      pix_q     <= pix_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      fs_q      <= fs_d;
      busy_q    <= busy_d;
    end
  end

  assign cfg_pending = pending_q;
  assign cfg_err     = err_q;
  assign pix_req     = pix_q;
  assign draw_area   = draw_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign pos_x       = h_pos;
  assign pos_y       = v_pos;
  assign frame_start = fs_q;
  assign busy        = busy_q;

endmodule
